// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser_pkg
// Description : Shared definitions for the UART command parser: ASCII
//               character codes, parser FSM states and response identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_parser_pkg;

  // ASCII characters recognised or emitted by the parser
  localparam logic [7:0] CH_S  = 8'h53;  // 'S'
  localparam logic [7:0] CH_Q  = 8'h3F;  // '?'
  localparam logic [7:0] CH_LF = 8'h0A;  // '\n'
  localparam logic [7:0] CH_CR = 8'h0D;  // '\r'
  localparam logic [7:0] CH_0  = 8'h30;  // '0'
  localparam logic [7:0] CH_9  = 8'h39;  // '9'
  localparam logic [7:0] CH_O  = 8'h4F;  // 'O'
  localparam logic [7:0] CH_K  = 8'h4B;  // 'K'
  localparam logic [7:0] CH_E  = 8'h45;  // 'E'
  localparam logic [7:0] CH_R  = 8'h52;  // 'R'
  localparam logic [7:0] CH_B  = 8'h42;  // 'B'

  // Parser FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DIGITS    = 3'd1,
    WAIT_LF_S = 3'd2,
    WAIT_LF_Q = 3'd3,
    SKIP      = 3'd4,
    RESP      = 3'd5
  } state_t;

  // Response selector handed to the sender
  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_ER  = 2'd1,
    RSP_BTN = 2'd2
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_resp.sv
`default_nettype none
// ============================================================================
// Module      : uart_resp_sender
// Description : Holds one response string ("OK\n", "ER\n" or "B<bits>\n") and
//               streams it out over a valid/ready handshake.
// Ports       : clk, rst_n     - clock, async active-low reset
//               load, rsp_id   - capture a new response (id selects text)
//               btn            - button levels captured for a "B" response
//               tx_ready       - downstream accepts byte when valid && ready
//               tx_data/valid  - current byte, held stable until accepted
//               done           - high in the cycle the last byte is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_sender
  import uart_cmd_parser_pkg::*;
#(
  parameter int NUM_BTNS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  rsp_t                rsp_id,
  input  logic [NUM_BTNS-1:0] btn,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  output logic                done
);

  localparam int DEPTH = NUM_BTNS + 2;
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       rsp_mem  [DEPTH];
  logic [7:0]       load_mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] load_last;

  // Text of the response to be captured on load
  always_comb begin
    for (int i = 0; i < DEPTH; i++) load_mem[i] = 8'h00;
    load_last = PTR_W'(2);
    case (rsp_id)
      RSP_OK: begin
        load_mem[0] = CH_O;
        load_mem[1] = CH_K;
        load_mem[2] = CH_LF;
      end
      RSP_BTN: begin
        load_mem[0] = CH_B;
        // '0' | bit gives '0' or '1'; BTN[0] is reported first
        for (int i = 0; i < NUM_BTNS; i++) load_mem[i+1] = CH_0 | {7'd0, btn[i]};
        load_mem[NUM_BTNS+1] = CH_LF;
        load_last = PTR_W'(NUM_BTNS + 1);
      end
      default: begin
        load_mem[0] = CH_E;
        load_mem[1] = CH_R;
        load_mem[2] = CH_LF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rsp_mem[i] <= 8'h00;
      ptr      <= '0;
      last     <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      rsp_mem  <= load_mem;
      ptr      <= '0;
      last     <= load_last;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (ptr == last) tx_valid <= 1'b0;
      else             ptr      <= ptr + 1'b1;
    end
  end

  // Pointer only moves on a handshake, so the byte is stable while stalled
  assign tx_data = rsp_mem[ptr];
  assign done    = tx_valid && tx_ready && (ptr == last);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Parses ASCII commands from the UART receiver: "Sddd\n" sets
//               the LED mask, "?\n" reports the buttons. Answers OK/ER/B...
//               towards the UART transmitter.
// Ports       : CLK, RST_N           - clock, async active-low reset
//               RX_DATA, RX_VALID    - received byte strobe
//               BTN                  - synchronised button levels
//               LED                  - LED mask register
//               TX_DATA, TX_VALID,
//               TX_READY             - response byte handshake
//               CMD_ERR              - pulse when an "ER" response is queued
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int NUM_LEDS       = 5,
  parameter int NUM_BTNS       = 3,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [7:0]          RX_DATA,
  input  logic                RX_VALID,
  input  logic [NUM_BTNS-1:0] BTN,
  output logic [NUM_LEDS-1:0] LED,
  output logic [7:0]          TX_DATA,
  output logic                TX_VALID,
  input  logic                TX_READY,
  output logic                CMD_ERR
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]       LED_MAX  = 10'((1 << NUM_LEDS) - 1);

  state_t           state, state_n;
  logic [9:0]       acc, acc_n;
  logic [1:0]       cnt, cnt_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic             load, led_we, done, rx_take, is_digit;
  rsp_t             rsp_sel;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      tmo     <= '0;
      LED     <= '0;
      CMD_ERR <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      tmo     <= tmo_n;
      if (led_we) LED <= acc[NUM_LEDS-1:0];
      CMD_ERR <= load && (rsp_sel == RSP_ER);
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    tmo_n   = tmo;
    load    = 1'b0;
    led_we  = 1'b0;
    rsp_sel = RSP_OK;
    // Carriage returns are invisible; nothing is taken while answering
    rx_take  = RX_VALID && (RX_DATA != CH_CR) && (state != RESP);
    is_digit = (RX_DATA >= CH_0) && (RX_DATA <= CH_9);

    if (state == RESP) begin
      tmo_n = '0;
      if (done) state_n = IDLE;
    end else if (rx_take) begin
      tmo_n = '0;
      case (state)
        IDLE: begin
          if (RX_DATA == CH_S) begin
            state_n = DIGITS;
            acc_n   = '0;
            cnt_n   = '0;
          end else if (RX_DATA == CH_Q) begin
            state_n = WAIT_LF_Q;
          end else if (RX_DATA != CH_LF) begin
            state_n = SKIP;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
            acc_n = acc * 10'd10 + {6'd0, RX_DATA[3:0]};
            cnt_n = cnt + 2'd1;
            if (cnt == 2'd2) state_n = WAIT_LF_S;
          end else if (RX_DATA == CH_LF) begin
            load    = 1'b1;
            rsp_sel = RSP_ER;
          end else begin
            state_n = SKIP;
          end
        end
        WAIT_LF_S: begin
          if (RX_DATA == CH_LF) begin
            load = 1'b1;
            if (acc <= LED_MAX) begin
              led_we  = 1'b1;
              rsp_sel = RSP_OK;
            end else begin
              rsp_sel = RSP_ER;
            end
          end else begin
            state_n = SKIP;
          end
        end
        WAIT_LF_Q: begin
          if (RX_DATA == CH_LF) begin
            load    = 1'b1;
            rsp_sel = RSP_BTN;
          end else begin
            state_n = SKIP;
          end
        end
        SKIP: begin
          if (RX_DATA == CH_LF) begin
            load    = 1'b1;
            rsp_sel = RSP_ER;
          end
        end
        default: state_n = IDLE;
      endcase
      if (load) state_n = RESP;
    end else if (state != IDLE) begin
      // Partial command abandoned silently once the line has gone quiet
      if (tmo == TMO_LAST) begin
        state_n = IDLE;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end else begin
      tmo_n = '0;
    end
  end

  uart_resp_sender #(
    .NUM_BTNS (NUM_BTNS)
  ) u_sender (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load),
    .rsp_id   (rsp_sel),
    .btn      (BTN),
    .tx_ready (TX_READY),
    .tx_data  (TX_DATA),
    .tx_valid (TX_VALID),
    .done     (done)
  );

endmodule
`default_nettype wire
